// File: rtl/motor_dir_ramp_ctrl.sv
// Direction/duty sequencer with linear ramping, dead-time reversal and glitch-free PWM.
// Optional low-side brake on define MOTOR_RAMP_BRAKE_EN.
module motor_dir_ramp_ctrl #(
    parameter int DUTY_W      = 8,
    parameter int PRESC_W     = 16,
    parameter int DEAD_CYCLES = 50
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [DUTY_W-1:0]  cmd_duty,
    input  logic [PRESC_W-1:0] ramp_div,
    input  logic               estop,
    output logic [DUTY_W-1:0]  duty_now,
    output logic               dir_out,
    output logic               pwm_out,
    output logic               busy,
    output logic               brake_out
);

    localparam int                DC_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DEAD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(2**DUTY_W - 2);

    typedef enum logic [1:0] {IDLE, DOWN, DEAD, RAMP} state_t;

    state_t             state;
    logic [DUTY_W-1:0]  target;
    logic [PRESC_W-1:0] presc;
    logic [DC_W-1:0]    dead_cnt;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic [DUTY_W-1:0]  shadow;
    logic [DUTY_W-1:0]  shadow_eff;
    logic               pwm_q;

    assign cmd_ready = (state == IDLE) & ~estop & ~ARESET;
    assign busy      = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            duty_now <= '0;
            dir_out  <= 1'b0;
            target   <= '0;
            presc    <= '0;
            dead_cnt <= '0;
        end else if (estop) begin
            // abort everything, including a pending flip in DEAD; direction is kept
            state    <= IDLE;
            duty_now <= '0;
            presc    <= '0;
            dead_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        target <= cmd_duty;
                        presc  <= '0;
                        if (cmd_dir == dir_out) begin
                            state <= RAMP;
                        end else if (duty_now == '0) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end else begin
                            state <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (duty_now == '0) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end else if (presc == ramp_div) begin
                        duty_now <= duty_now - 1'b1;
                        presc    <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DC_LAST) begin
                        dir_out <= ~dir_out;
                        state   <= RAMP;
                        presc   <= '0;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                RAMP: begin
                    if (duty_now == target) begin
                        state <= IDLE;
                    end else if (presc == ramp_div) begin
                        duty_now <= (duty_now < target) ? duty_now + 1'b1 : duty_now - 1'b1;
                        presc    <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // the compare at count 0 must already use the newly loaded duty, or period start glitches
    always_comb begin
        shadow_eff = shadow;
        if (pwm_cnt == '0) shadow_eff = duty_now;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pwm_cnt <= '0;
            shadow  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + 1'b1;
            if (estop) begin
                shadow <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (pwm_cnt == '0) shadow <= duty_now;
                pwm_q <= (pwm_cnt < shadow_eff);
            end
        end
    end

`ifdef MOTOR_RAMP_BRAKE_EN
    assign brake_out = (state == DEAD) | estop;
    assign pwm_out   = pwm_q & ~brake_out;
`else
    assign brake_out = 1'b0;
    assign pwm_out   = pwm_q;
`endif

endmodule

// File: tb/tb_motor_dir_ramp_ctrl.sv
// Directed bench for motor_dir_ramp_ctrl: reset, ramp, PWM, reversal, estop, reset mid-ramp.
module tb_motor_dir_ramp_ctrl;

`ifdef MOTOR_RAMP_BRAKE_EN
    localparam int BRAKE = 1;
`else
    localparam int BRAKE = 0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [7:0]  cmd_duty = '0;
    logic [15:0] ramp_div = '0;
    logic        estop = 1'b0;
    logic [7:0]  duty_now;
    logic        dir_out;
    logic        pwm_out;
    logic        busy;
    logic        brake_out;

    int n_chk = 0;
    int n_err = 0;

    motor_dir_ramp_ctrl #(.DUTY_W(8), .PRESC_W(16), .DEAD_CYCLES(50)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .ramp_div(ramp_div), .estop(estop),
        .duty_now(duty_now), .dir_out(dir_out), .pwm_out(pwm_out), .busy(busy),
        .brake_out(brake_out)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_cmd(input logic d, input int duty);
        int n = 0;
        while (!cmd_ready && n < 5000) begin tick(); n++; end
        chk("ready_timeout", int'(n < 5000), 1);
        cmd_dir = d; cmd_duty = 8'(duty); cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        chk("idle_timeout", int'(n < 5000), 1);
    endtask

    task automatic pwm_measure(output int hi, output int edges);
        logic prev;
        hi = 0; edges = 0; prev = pwm_out;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (pwm_out) hi++;
            if (pwm_out != prev) edges++;
            prev = pwm_out;
        end
    endtask

    initial begin
        int hi, edges, nbrk, npwm_brk;

        // T1 reset
        repeat (5) tick();
        chk("rst_duty", duty_now, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_brake", brake_out, 0);
        chk("rst_ready", cmd_ready, 0);
        ARESET = 1'b0;
        #1;
        chk("rst_ready_rise", cmd_ready, 1);

        // T2 same-direction ramp, one step every 4 cycles
        ramp_div = 16'd3;
        send_cmd(1'b0, 100);
        chk("t2_busy", busy, 1);
        repeat (3) tick();
        chk("t2_duty_3", duty_now, 0);
        tick();
        chk("t2_duty_4", duty_now, 1);
        repeat (395) tick();
        chk("t2_duty_399", duty_now, 99);
        tick();
        chk("t2_duty_400", duty_now, 100);
        chk("t2_busy_400", busy, 1);
        tick();
        chk("t2_idle", busy, 0);
        chk("t2_hold", duty_now, 100);

        // T4 PWM duty 64, 0, 255
        ramp_div = 16'd0;
        send_cmd(1'b0, 64);
        wait_idle();
        repeat (300) tick();
        pwm_measure(hi, edges);
        chk("pwm64_high", hi, 64);
        chk("pwm64_edges_le2", int'(edges <= 2), 1);
        send_cmd(1'b0, 0);
        wait_idle();
        repeat (300) tick();
        pwm_measure(hi, edges);
        chk("pwm0_high", hi, 0);
        send_cmd(1'b0, 255);
        wait_idle();
        repeat (300) tick();
        pwm_measure(hi, edges);
        chk("pwm255_high", hi, 255);
        chk("pwm255_edges", edges, 0);

        // T3 reversal from dir0/20 to dir1/10
        send_cmd(1'b0, 20);
        wait_idle();
        chk("t3_start", duty_now, 20);
        send_cmd(1'b1, 10);
        chk("t3_busy", busy, 1);
        repeat (19) tick();
        chk("t3_duty_19", duty_now, 1);
        tick();
        chk("t3_duty_20", duty_now, 0);
        chk("t3_brake_pre", brake_out, 0);
        nbrk = 0; npwm_brk = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (brake_out) nbrk++;
            if (brake_out && pwm_out) npwm_brk++;
        end
        chk("t6_brake_cycles", nbrk, 50 * BRAKE);
        chk("t6_pwm_in_brake", npwm_brk, 0);
        chk("t3_dir_before_flip", dir_out, 0);
        tick();
        chk("t3_dir_flip", dir_out, 1);
        chk("t3_brake_post", brake_out, 0);
        chk("t3_duty_flip", duty_now, 0);
        repeat (10) tick();
        chk("t3_duty_up", duty_now, 10);
        chk("t3_busy_up", busy, 1);
        tick();
        chk("t3_idle", busy, 0);

        // equal command: one-cycle busy pulse
        send_cmd(1'b1, 10);
        chk("eq_busy", busy, 1);
        tick();
        chk("eq_idle", busy, 0);
        chk("eq_duty", duty_now, 10);

        // T5 estop mid-DOWN with a command present
        ramp_div = 16'd3;
        send_cmd(1'b0, 50);
        repeat (5) tick();
        chk("t5_down_duty", duty_now, 9);
        chk("t5_down_busy", busy, 1);
        estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_duty = 8'd200;
        #1;
        chk("t5_ready_estop", cmd_ready, 0);
        tick();
        chk("t5_duty", duty_now, 0);
        chk("t5_pwm", pwm_out, 0);
        chk("t5_dir", dir_out, 1);
        chk("t5_busy", busy, 0);
        chk("t5_brake", brake_out, BRAKE);
        repeat (3) tick();
        chk("t5_hold_busy", busy, 0);
        chk("t5_hold_pwm", pwm_out, 0);
        estop = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("t5_ready_rise", cmd_ready, 1);
        repeat (5) tick();
        chk("t5_cmd_ignored", busy, 0);
        chk("t5_duty_zero", duty_now, 0);
        chk("t5_dir_kept", dir_out, 1);

        // estop beats an accept in IDLE
        estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_duty = 8'd30;
        tick();
        estop = 1'b0; cmd_valid = 1'b0;
        tick();
        chk("estop_vs_accept", busy, 0);

        // ARESET mid-ramp
        ramp_div = 16'd0;
        send_cmd(1'b1, 100);
        repeat (10) tick();
        chk("mid_duty", duty_now, 10);
        ARESET = 1'b1;
        tick();
        chk("mid_rst_duty", duty_now, 0);
        chk("mid_rst_dir", dir_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        ARESET = 1'b0;
        #1;
        chk("mid_rst_ready_rise", cmd_ready, 1);
        repeat (3) tick();
        chk("mid_rst_no_pending", busy, 0);
        chk("mid_rst_duty_hold", duty_now, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
